// File: rtl/ge_sched_pkg.sv
// Shared types and defaults for the frame maximum scheduler.
package ge_sched_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/ge_max_scheduler_gecell.sv
// Unsigned greater-or-equal comparator cell; the only magnitude compare in the scheduler.
module GeCell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out
);

  assign out = (a >= b);

endmodule

// File: rtl/ge_max_scheduler.sv
// Buffers a frame of DEPTH words, then walks it through one shared GeCell to find
// the maximum and its earliest index, returned over a valid/ready output.
//
// state      | meaning
// LOAD       | accepting frame words into the buffer
// COMPARE    | one buffer entry per cycle against the running maximum
// DONE       | result held on the output until the consumer takes it
module ge_max_scheduler
  import ge_sched_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);

  localparam logic [IDXW:0] LAST = (IDXW+1)'(DEPTH-1);
  localparam logic [IDXW:0] ONE  = (IDXW+1)'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [IDXW:0]    r_wr_ptr;
  logic [IDXW:0]    r_cmp_ptr;
  logic [WIDTH-1:0] r_max;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] w_cmp_b;
  logic             w_ge;
  logic             w_accept;

  assign w_cmp_b  = r_buf[r_cmp_ptr[IDXW-1:0]];
  assign w_accept = in_valid & in_ready;

  GeCell #(.WIDTH(WIDTH)) u_ge (
    .a   (r_max),
    .b   (w_cmp_b),
    .out (w_ge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD:    if (w_accept && (r_wr_ptr == LAST)) w_next_state = ST_COMPARE;
      ST_COMPARE: if (r_cmp_ptr == LAST)              w_next_state = ST_DONE;
      ST_DONE:    if (out_ready)                      w_next_state = ST_LOAD;
      default:                                        w_next_state = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_LOAD:    in_ready  = 1'b1;
      ST_COMPARE: busy      = 1'b1;
      ST_DONE:    out_valid = 1'b1;
      default:    ;
    endcase
  end

  assign out_max = r_max;
  assign out_idx = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr  <= '0;
      r_cmp_ptr <= '0;
      r_max     <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_buf[r_wr_ptr[IDXW-1:0]] <= in_data;
            r_wr_ptr                  <= r_wr_ptr + ONE;
            // Word 0 seeds the running maximum once the frame is complete.
            if (r_wr_ptr == LAST) begin
              r_max     <= r_buf[0];
              r_idx     <= '0;
              r_cmp_ptr <= ONE;
            end
          end
        end
        ST_COMPARE: begin
          // Replace only on strictly greater so the earliest index wins ties.
          if (!w_ge) begin
            r_max <= w_cmp_b;
            r_idx <= r_cmp_ptr[IDXW-1:0];
          end
          r_cmp_ptr <= r_cmp_ptr + ONE;
        end
        ST_DONE: begin
          if (out_ready) r_wr_ptr <= '0;
        end
        default: r_wr_ptr <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ge_max_scheduler.sv
// Directed self-checking bench for ge_max_scheduler at WIDTH=4, DEPTH=4.
module tb_ge_max_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [1:0] out_idx;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  ge_max_scheduler #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] w0, w1, w2, w3;
    logic [3:0] exp_max;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    check("send_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [3:0] emax,
                             input logic [1:0] eidx, input int elat);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check({name, "_latency"}, t, elat);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_max"}, int'(out_max), int'(emax));
    check({name, "_idx"}, int'(out_idx), int'(eidx));
    check({name, "_in_ready_done"}, int'(in_ready), 0);
  endtask

  initial begin
    vecs[0] = '{4'd2,  4'd0, 4'd3, 4'd1,  4'd3,  2'd2};
    vecs[1] = '{4'd5,  4'd7, 4'd7, 4'd1,  4'd7,  2'd1};
    vecs[2] = '{4'd0,  4'd0, 4'd0, 4'd0,  4'd0,  2'd0};
    vecs[3] = '{4'd4,  4'd6, 4'd3, 4'd2,  4'd6,  2'd1};
    vecs[4] = '{4'd1,  4'd2, 4'd3, 4'd4,  4'd4,  2'd3};
    vecs[5] = '{4'd9,  4'd9, 4'd9, 4'd9,  4'd9,  2'd0};
    vecs[6] = '{4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 2'd0};
    vecs[7] = '{4'd0,  4'd0, 4'd0, 4'd1,  4'd1,  2'd3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_max", int'(out_max), 0);
    check("rst_out_idx", int'(out_idx), 0);
    rst_n = 1'b1;
    step();

    // Table frames, gapless then with a bubble after every word.
    for (int g = 0; g < 2; g++) begin
      for (int v = 0; v < 8; v++) begin
        logic [3:0] ws [4];
        ws[0] = vecs[v].w0; ws[1] = vecs[v].w1; ws[2] = vecs[v].w2; ws[3] = vecs[v].w3;
        for (int k = 0; k < 4; k++) begin
          send(ws[k]);
          if (g == 1 && k < 3) step();
        end
        check("busy_after_last", int'(busy), 1);
        wait_result("vec", vecs[v].exp_max, vecs[v].exp_idx, 3);
        step();
        check("vec_back_to_load", int'(in_ready), 1);
        check("vec_valid_drop", int'(out_valid), 0);
      end
    end

    // Input held during COMPARE/DONE must wait for the result handshake.
    send(4'd2); send(4'd0); send(4'd3); send(4'd1);
    in_valid  = 1'b1;
    in_data   = 4'd9;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("hold_in_ready", int'(in_ready), 0);
      step();
    end
    check("hold_result_max", int'(out_max), 3);
    check("hold_result_idx", int'(out_idx), 2);
    out_ready = 1'b1;
    step();
    check("hold_load_ready", int'(in_ready), 1);
    send(4'd9); send(4'd1); send(4'd2); send(4'd3);
    wait_result("held9", 4'd9, 2'd0, 3);
    step();

    // Output backpressure: result stable for 5 cycles, handshake on the 6th.
    out_ready = 1'b0;
    send(4'd4); send(4'd6); send(4'd3); send(4'd2);
    wait_result("bp", 4'd6, 2'd1, 3);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", int'(out_valid), 1);
      check("bp_max", int'(out_max), 6);
      check("bp_idx", int'(out_idx), 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);

    // Reset after two words of a frame.
    send(4'd1); send(4'd5);
    rst_n = 1'b0;
    #2;
    check("rstA_in_ready", int'(in_ready), 1);
    check("rstA_out_valid", int'(out_valid), 0);
    check("rstA_busy", int'(busy), 0);
    #4;
    rst_n = 1'b1;
    step();
    // Reset in the middle of COMPARE.
    send(4'd7); send(4'd8); send(4'd9); send(4'd10);
    step();
    check("rstB_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    check("rstB_busy", int'(busy), 0);
    check("rstB_out_max", int'(out_max), 0);
    check("rstB_out_idx", int'(out_idx), 0);
    check("rstB_in_ready", int'(in_ready), 1);
    check("rstB_out_valid", int'(out_valid), 0);
    #4;
    rst_n = 1'b1;
    step();
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    wait_result("post_rst", 4'd4, 2'd3, 3);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
